// File: rtl/tile_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : tile_blitter
//  Description : Mask-draw engine for the block framebuffer. Fetches a
//                2-bit/pixel mask, shifts it by a pixel offset across up to
//                2x2 destination blocks, clips against the grid edges, skips
//                untouched blocks and performs one read-modify-write per
//                touched block.
//  Revision    : 1.0 - initial release
// ============================================================================
module tile_blitter #(
  parameter  int BLK_W   = 8,
  parameter  int BLK_H   = 8,
  parameter  int CBITS   = 4,
  parameter  int GRID_W  = 100,
  parameter  int GRID_H  = 60,
  parameter  int MASK_AW = 8,
  localparam int OXW     = $clog2(BLK_W),
  localparam int OYW     = $clog2(BLK_H),
  localparam int PIX     = BLK_W * BLK_H,
  localparam int MW      = 2 * PIX,
  localparam int CW      = PIX * CBITS,
  localparam int GRID_XB = $clog2(GRID_W),
  localparam int GRID_YB = $clog2(GRID_H)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic [GRID_XB-1:0]         cmd_blk_x,
  input  logic [GRID_YB-1:0]         cmd_blk_y,
  input  logic [OXW-1:0]             cmd_off_x,
  input  logic [OYW-1:0]             cmd_off_y,
  input  logic [MASK_AW-1:0]         cmd_mask_id,
  input  logic [3*CBITS-1:0]         cmd_primary,
  input  logic [3*CBITS-1:0]         cmd_secondary,
  output logic                       mask_rd,
  output logic [MASK_AW-1:0]         mask_addr,
  input  logic [MW-1:0]              mask_data,
  output logic                       fb_rd,
  output logic                       fb_wr,
  output logic [GRID_XB+GRID_YB-1:0] fb_addr,
  input  logic [3*CW-1:0]            fb_rdata,
  output logic [3*CW-1:0]            fb_wdata,
  output logic                       busy,
  output logic                       done,
  output logic [2:0]                 blk_count
);

  // Grid limits sized to the one-bit-wider target coordinates.
  localparam logic [GRID_XB:0] LIM_X = (GRID_XB + 1)'(GRID_W);
  localparam logic [GRID_YB:0] LIM_Y = (GRID_YB + 1)'(GRID_H);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_MASK_RD  = 3'd1,
    S_MASK_CAP = 3'd2,
    S_FB_RD    = 3'd3,
    S_FB_CAP   = 3'd4,
    S_FB_WR    = 3'd5,
    S_DONE     = 3'd6
  } state_t;

  state_t                     state_q;

  // Registered port outputs
  logic                       cmd_ready_q;
  logic                       busy_q;
  logic                       done_q;
  logic                       mask_rd_q;
  logic                       fb_rd_q;
  logic                       fb_wr_q;
  logic [MASK_AW-1:0]         mask_addr_q;
  logic [GRID_XB+GRID_YB-1:0] fb_addr_q;
  logic [3*CW-1:0]            fb_wdata_q;
  logic [2:0]                 blk_count_q;

  // Command fields latched at accept
  logic [GRID_XB-1:0]         blk_x_q;
  logic [GRID_YB-1:0]         blk_y_q;
  logic [OXW-1:0]             off_x_q;
  logic [OYW-1:0]             off_y_q;
  logic [3*CBITS-1:0]         prim_q;
  logic [3*CBITS-1:0]         sec_q;

  // Working state
  logic [MW-1:0]              mask_q;
  logic [3:0]                 pending_q;
  logic [1:0]                 cur_q;

  // Combinational next-state helpers
  logic [MW-1:0]              mask_src;
  logic [3:0][MW-1:0]         shift_map;
  logic [MW-1:0]              cur_map;
  logic [GRID_XB:0]           x_nxt;
  logic [GRID_YB:0]           y_nxt;
  logic [1:0]                 x_ok;
  logic [1:0]                 y_ok;
  logic [3:0]                 pending_d;
  logic [3:0]                 remain_d;
  logic [1:0]                 nxt_q_d;
  logic [GRID_XB+GRID_YB-1:0] nxt_addr_d;
  logic [3*CW-1:0]            wdata_d;

  // Lowest set quadrant index; callers only use it when the vector is nonzero.
  function automatic logic [1:0] lowest(input logic [3:0] v);
    if (v[0])      return 2'd0;
    else if (v[1]) return 2'd1;
    else if (v[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  // The shift network sees the live mask bus while capturing, the stored copy afterwards.
  assign mask_src = (state_q == S_MASK_CAP) ? mask_data : mask_q;

  // Scatter every mask pixel into its destination quadrant at its wrapped in-block position.
  always_comb begin : shift_net
    logic [OXW:0]       sx;
    logic [OYW:0]       sy;
    logic [1:0]         qd;
    logic [OXW+OYW-1:0] dst;
    sx        = '0;
    sy        = '0;
    qd        = '0;
    dst       = '0;
    shift_map = '0;
    for (int py = 0; py < BLK_H; py++) begin
      for (int px = 0; px < BLK_W; px++) begin
        sx  = {1'b0, off_x_q} + px[OXW:0];
        sy  = {1'b0, off_y_q} + py[OYW:0];
        qd  = {sy[OYW], sx[OXW]};
        dst = {sy[OYW-1:0], sx[OXW-1:0]};
        shift_map[qd][2*dst +: 2] = mask_src[2*(py*BLK_W+px) +: 2];
      end
    end
  end

  // A quadrant is worth visiting only if it receives a nonzero code and lies inside the grid.
  always_comb begin
    x_nxt        = {1'b0, blk_x_q} + {{GRID_XB{1'b0}}, 1'b1};
    y_nxt        = {1'b0, blk_y_q} + {{GRID_YB{1'b0}}, 1'b1};
    x_ok[0]      = ({1'b0, blk_x_q} < LIM_X);
    x_ok[1]      = (x_nxt < LIM_X);
    y_ok[0]      = ({1'b0, blk_y_q} < LIM_Y);
    y_ok[1]      = (y_nxt < LIM_Y);
    pending_d[0] = (|shift_map[0]) & x_ok[0] & y_ok[0];
    pending_d[1] = (|shift_map[1]) & x_ok[1] & y_ok[0];
    pending_d[2] = (|shift_map[2]) & x_ok[0] & y_ok[1];
    pending_d[3] = (|shift_map[3]) & x_ok[1] & y_ok[1];
  end

  // Pick the next quadrant to visit and form its block address.
  always_comb begin
    remain_d   = pending_q & ~(4'b0001 << cur_q);
    nxt_q_d    = (state_q == S_MASK_CAP) ? lowest(pending_d) : lowest(remain_d);
    nxt_addr_d = {blk_x_q + {{(GRID_XB-1){1'b0}}, nxt_q_d[0]},
                  blk_y_q + {{(GRID_YB-1){1'b0}}, nxt_q_d[1]}};
  end

  assign cur_map = shift_map[cur_q];

  // Per-pixel, per-channel merge of the old block with the draw codes of the current quadrant.
  always_comb begin : merge
    logic [1:0]       code;
    logic [CBITS-1:0] old;
    code    = '0;
    old     = '0;
    wdata_d = fb_rdata;
    for (int p = 0; p < PIX; p++) begin
      code = cur_map[2*p +: 2];
      for (int ch = 0; ch < 3; ch++) begin
        old = fb_rdata[ch*CW + p*CBITS +: CBITS];
        case (code)
          2'b01:   wdata_d[ch*CW + p*CBITS +: CBITS] = prim_q[ch*CBITS +: CBITS];
          2'b10:   wdata_d[ch*CW + p*CBITS +: CBITS] = sec_q[ch*CBITS +: CBITS];
          2'b11:   wdata_d[ch*CW + p*CBITS +: CBITS] = ~old;
          default: wdata_d[ch*CW + p*CBITS +: CBITS] = old;
        endcase
      end
    end
  end

  // Command sequencer: one state per cycle, every port strobe registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      mask_rd_q   <= 1'b0;
      fb_rd_q     <= 1'b0;
      fb_wr_q     <= 1'b0;
      mask_addr_q <= '0;
      fb_addr_q   <= '0;
      fb_wdata_q  <= '0;
      blk_count_q <= '0;
      blk_x_q     <= '0;
      blk_y_q     <= '0;
      off_x_q     <= '0;
      off_y_q     <= '0;
      prim_q      <= '0;
      sec_q       <= '0;
      mask_q      <= '0;
      pending_q   <= '0;
      cur_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            blk_x_q     <= cmd_blk_x;
            blk_y_q     <= cmd_blk_y;
            off_x_q     <= cmd_off_x;
            off_y_q     <= cmd_off_y;
            prim_q      <= cmd_primary;
            sec_q       <= cmd_secondary;
            mask_addr_q <= cmd_mask_id;
            mask_rd_q   <= 1'b1;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            blk_count_q <= '0;
            state_q     <= S_MASK_RD;
          end
        end
        S_MASK_RD: begin
          mask_rd_q <= 1'b0;
          state_q   <= S_MASK_CAP;
        end
        S_MASK_CAP: begin
          mask_q    <= mask_data;
          pending_q <= pending_d;
          if (|pending_d) begin
            cur_q     <= nxt_q_d;
            fb_addr_q <= nxt_addr_d;
            fb_rd_q   <= 1'b1;
            state_q   <= S_FB_RD;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_FB_RD: begin
          fb_rd_q <= 1'b0;
          state_q <= S_FB_CAP;
        end
        S_FB_CAP: begin
          fb_wdata_q  <= wdata_d;
          fb_wr_q     <= 1'b1;
          blk_count_q <= blk_count_q + 3'd1;
          state_q     <= S_FB_WR;
        end
        S_FB_WR: begin
          fb_wr_q   <= 1'b0;
          pending_q <= remain_d;
          if (|remain_d) begin
            cur_q     <= nxt_q_d;
            fb_addr_q <= nxt_addr_d;
            fb_rd_q   <= 1'b1;
            state_q   <= S_FB_RD;
          end else begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q      <= 1'b0;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign mask_rd   = mask_rd_q;
  assign mask_addr = mask_addr_q;
  assign fb_rd     = fb_rd_q;
  assign fb_wr     = fb_wr_q;
  assign fb_addr   = fb_addr_q;
  assign fb_wdata  = fb_wdata_q;
  assign blk_count = blk_count_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_blitter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tile_blitter
//  Description : Self-checking bench for tile_blitter. Mask and frame memories
//                are modelled here; expected writes come from a global-pixel
//                reference model of the draw rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tile_blitter;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [6:0]   cmd_blk_x;
  logic [5:0]   cmd_blk_y;
  logic [2:0]   cmd_off_x;
  logic [2:0]   cmd_off_y;
  logic [7:0]   cmd_mask_id;
  logic [11:0]  cmd_primary;
  logic [11:0]  cmd_secondary;
  logic         mask_rd;
  logic [7:0]   mask_addr;
  logic [127:0] mask_data;
  logic         fb_rd;
  logic         fb_wr;
  logic [12:0]  fb_addr;
  logic [767:0] fb_rdata;
  logic [767:0] fb_wdata;
  logic         busy;
  logic         done;
  logic [2:0]   blk_count;

  tile_blitter dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_blk_x     (cmd_blk_x),
    .cmd_blk_y     (cmd_blk_y),
    .cmd_off_x     (cmd_off_x),
    .cmd_off_y     (cmd_off_y),
    .cmd_mask_id   (cmd_mask_id),
    .cmd_primary   (cmd_primary),
    .cmd_secondary (cmd_secondary),
    .mask_rd       (mask_rd),
    .mask_addr     (mask_addr),
    .mask_data     (mask_data),
    .fb_rd         (fb_rd),
    .fb_wr         (fb_wr),
    .fb_addr       (fb_addr),
    .fb_rdata      (fb_rdata),
    .fb_wdata      (fb_wdata),
    .busy          (busy),
    .done          (done),
    .blk_count     (blk_count)
  );

  always #5 clk = ~clk;

  logic [127:0] mask_mem [256];
  logic [767:0] fb_mem   [8192];
  logic [12:0]  wr_addr_log [$];
  logic [767:0] wr_data_log [$];
  int           rd_cnt  = 0;
  int           oob_cnt = 0;
  logic [12:0]  exp_addr [$];
  logic [767:0] exp_data [$];
  int           n_vec  = 0;
  int           n_miss = 0;

  // Memory responders: read data one cycle after the strobe, writes logged for the bench.
  always @(posedge clk) begin
    if (mask_rd) mask_data <= mask_mem[mask_addr];
    if (fb_rd) begin
      fb_rdata <= fb_mem[fb_addr];
      rd_cnt   <= rd_cnt + 1;
      if (fb_addr[12:6] >= 7'd100 || fb_addr[5:0] >= 6'd60) oob_cnt <= oob_cnt + 1;
    end
    if (fb_wr) begin
      wr_addr_log.push_back(fb_addr);
      wr_data_log.push_back(fb_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [767:0] got, input logic [767:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] addr_of(input int x, input int y);
    return {x[6:0], y[5:0]};
  endfunction

  // Reference: paint each nonzero mask pixel at its global pixel coordinate, then
  // emit every touched in-grid block in quadrant order.
  task automatic model_cmd(input int bx, input int by, input int ox, input int oy,
                           input logic [127:0] m, input logic [11:0] pri, input logic [11:0] sec);
    logic [767:0] blk [4];
    bit           hit [4];
    exp_addr.delete();
    exp_data.delete();
    for (int q = 0; q < 4; q++) begin
      hit[q] = 1'b0;
      blk[q] = '0;
    end
    for (int py = 0; py < 8; py++) begin
      for (int px = 0; px < 8; px++) begin
        logic [1:0] code;
        logic [3:0] old;
        logic [3:0] nv;
        int gx, gy, tx, ty, q, p;
        code = m[2*(py*8+px) +: 2];
        gx = bx*8 + ox + px;
        gy = by*8 + oy + py;
        tx = gx / 8;
        ty = gy / 8;
        if (code != 2'b00 && tx < 100 && ty < 60) begin
          q = (ty - by)*2 + (tx - bx);
          if (!hit[q]) begin
            hit[q] = 1'b1;
            blk[q] = fb_mem[addr_of(tx, ty)];
          end
          p = (gy % 8)*8 + (gx % 8);
          for (int ch = 0; ch < 3; ch++) begin
            old = blk[q][ch*256 + p*4 +: 4];
            case (code)
              2'b01:   nv = pri[ch*4 +: 4];
              2'b10:   nv = sec[ch*4 +: 4];
              default: nv = ~old;
            endcase
            blk[q][ch*256 + p*4 +: 4] = nv;
          end
        end
      end
    end
    for (int q = 0; q < 4; q++) begin
      if (hit[q]) begin
        exp_addr.push_back(addr_of(bx + q % 2, by + q / 2));
        exp_data.push_back(blk[q]);
      end
    end
  endtask

  // Issue one command, scramble the inputs while busy, and check timing, count and writes.
  task automatic do_cmd(input string tag, input int bx, input int by, input int ox, input int oy,
                        input int mid, input logic [11:0] pri, input logic [11:0] sec,
                        output int wbase);
    int n, rb, ob, nexp;
    model_cmd(bx, by, ox, oy, mask_mem[mid], pri, sec);
    nexp  = exp_addr.size();
    wbase = wr_addr_log.size();
    rb    = rd_cnt;
    ob    = oob_cnt;
    cmd_blk_x     = 7'(bx);
    cmd_blk_y     = 6'(by);
    cmd_off_x     = 3'(ox);
    cmd_off_y     = 3'(oy);
    cmd_mask_id   = 8'(mid);
    cmd_primary   = pri;
    cmd_secondary = sec;
    cmd_valid     = 1'b1;
    @(posedge clk); #1;
    cmd_valid     = 1'b0;
    cmd_blk_x     = 7'($urandom);
    cmd_blk_y     = 6'($urandom);
    cmd_off_x     = 3'($urandom);
    cmd_off_y     = 3'($urandom);
    cmd_mask_id   = 8'($urandom);
    cmd_primary   = 12'($urandom);
    cmd_secondary = 12'($urandom);
    n = 0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "/done_cycle"}, 768'(n + 1), 768'(3 + 3*nexp));
    check_eq({tag, "/blk_count"}, 768'(blk_count), 768'(nexp));
    @(posedge clk); #1;
    check_eq({tag, "/ready_after"}, 768'(cmd_ready), 768'(1));
    check_eq({tag, "/n_wr"}, 768'(wr_addr_log.size() - wbase), 768'(nexp));
    check_eq({tag, "/n_rd"}, 768'(rd_cnt - rb), 768'(nexp));
    check_eq({tag, "/oob"}, 768'(oob_cnt - ob), 768'(0));
    for (int i = 0; i < nexp && wbase + i < wr_addr_log.size(); i++) begin
      check_eq({tag, "/wr_addr"}, 768'(wr_addr_log[wbase+i]), 768'(exp_addr[i]));
      check_eq({tag, "/wr_data"}, wr_data_log[wbase+i], exp_data[i]);
    end
    for (int i = wbase; i < wr_addr_log.size(); i++) fb_mem[wr_addr_log[i]] = wr_data_log[i];
  endtask

  // The canonical single-block draw: all reds F, greens and blues 0 at {3,2}.
  task automatic t1_extra(input string tag, input int wb);
    if (wr_addr_log.size() > wb) begin
      check_eq({tag, "/addr32"}, 768'(wr_addr_log[wb]), 768'(addr_of(3, 2)));
      check_eq({tag, "/red_only"}, wr_data_log[wb], {512'd0, {64{4'hF}}});
    end else begin
      check_eq({tag, "/has_wr"}, 768'(wr_addr_log.size() - wb), 768'(1));
    end
  endtask

  initial begin
    int           wb;
    int           n;
    logic [767:0] old42;
    logic [255:0] red_exp;
    logic [127:0] r;

    cmd_valid = 1'b0; cmd_blk_x = '0; cmd_blk_y = '0; cmd_off_x = '0; cmd_off_y = '0;
    cmd_mask_id = '0; cmd_primary = '0; cmd_secondary = '0;

    for (int a = 0; a < 8192; a++)
      for (int w = 0; w < 24; w++) fb_mem[a][w*32 +: 32] = $urandom;
    for (int i = 0; i < 256; i++) begin
      int pos;
      for (int w = 0; w < 4; w++) r[w*32 +: 32] = $urandom;
      if (i < 64) begin
        pos = $urandom_range(0, 63);
        r = '0;
        r[2*pos +: 2] = 2'($urandom_range(1, 3));
      end else if (i < 128) begin
        for (int w = 0; w < 4; w++) r[w*32 +: 32] = r[w*32 +: 32] & $urandom & $urandom;
      end else if (i % 50 == 0) begin
        r = '0;
      end
      mask_mem[i] = r;
    end
    for (int p = 0; p < 64; p++) r[2*p +: 2] = 2'(p % 4);
    mask_mem[240] = r;
    mask_mem[250] = {64{2'b01}};
    mask_mem[251] = {64{2'b11}};
    mask_mem[252] = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst/cmd_ready", 768'(cmd_ready), 768'(1));
    check_eq("rst/busy", 768'(busy), 768'(0));
    check_eq("rst/strobes", 768'({mask_rd, fb_rd, fb_wr, done}), 768'(0));
    check_eq("rst/blk_count", 768'(blk_count), 768'(0));
    check_eq("rst/addrs", 768'({fb_addr, mask_addr}), 768'(0));
    check_eq("rst/fb_wdata", fb_wdata, 768'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: single block, all primary
    do_cmd("t1", 3, 2, 0, 0, 250, 12'h00F, 12'hABC, wb);
    t1_extra("t1", wb);

    // 2: offset spills into all four quadrants
    old42 = fb_mem[addr_of(4, 2)];
    do_cmd("t2", 3, 2, 3, 5, 250, 12'h00F, 12'h123, wb);
    if (wr_addr_log.size() > wb + 1) begin
      check_eq("t2/second_addr", 768'(wr_addr_log[wb+1]), 768'(addr_of(4, 2)));
      check_eq("t2/untouched_px", 768'(wr_data_log[wb+1][43*4 +: 4]), 768'(old42[43*4 +: 4]));
      check_eq("t2/drawn_px", 768'(wr_data_log[wb+1][49*4 +: 4]), 768'(4'hF));
    end

    // 3: corner block, everything beyond the grid clipped
    do_cmd("t3", 99, 59, 4, 4, 251, 12'h555, 12'hAAA, wb);
    if (wr_addr_log.size() > wb)
      check_eq("t3/addr", 768'(wr_addr_log[wb]), 768'(addr_of(99, 59)));

    // 4: every draw code over old red = 3
    fb_mem[addr_of(10, 10)][255:0] = {64{4'h3}};
    for (int p = 0; p < 64; p++) begin
      case (p % 4)
        0:       red_exp[p*4 +: 4] = 4'h3;
        1:       red_exp[p*4 +: 4] = 4'h5;
        2:       red_exp[p*4 +: 4] = 4'h9;
        default: red_exp[p*4 +: 4] = 4'hC;
      endcase
    end
    do_cmd("t4", 10, 10, 0, 0, 240, 12'h125, 12'h3A9, wb);
    if (wr_addr_log.size() > wb)
      check_eq("t4/reds", 768'(wr_data_log[wb][255:0]), 768'(red_exp));

    // 5: empty mask touches nothing
    do_cmd("t5", 20, 20, 2, 2, 252, 12'hFFF, 12'hFFF, wb);

    // 6: reset during FB_CAP aborts the write
    wb = wr_addr_log.size();
    cmd_blk_x = 7'd3; cmd_blk_y = 6'd2; cmd_off_x = 3'd0; cmd_off_y = 3'd0;
    cmd_mask_id = 8'd250; cmd_primary = 12'h00F; cmd_secondary = 12'h000;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    n = 0;
    while (fb_rd !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("t6/fb_rd_seen", 768'(fb_rd), 768'(1));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("t6/abort_outs", 768'({fb_wr, busy, done, mask_rd, fb_rd}), 768'(0));
    check_eq("t6/abort_ready", 768'(cmd_ready), 768'(1));
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check_eq("t6/no_wr", 768'(wr_addr_log.size() - wb), 768'(0));
    check_eq("t6/idle_after", 768'({cmd_ready, busy}), 768'(2'b10));
    do_cmd("t6_t1", 3, 2, 0, 0, 250, 12'h00F, 12'hABC, wb);
    t1_extra("t6_t1", wb);

    // Randomized commands, biased towards grid edges
    for (int k = 0; k < 40; k++) begin
      int bx, by, mid;
      bx  = ($urandom_range(0, 3) == 0) ? 98 + $urandom_range(0, 1) : $urandom_range(0, 99);
      by  = ($urandom_range(0, 3) == 0) ? 58 + $urandom_range(0, 1) : $urandom_range(0, 59);
      mid = $urandom_range(0, 239);
      do_cmd("rnd", bx, by, $urandom_range(0, 7), $urandom_range(0, 7), mid,
             12'($urandom), 12'($urandom), wb);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
